// File: rtl/sprite_line_evaluator.sv
`default_nettype none
// ============================================================================
// Module  : sprite_line_evaluator
// Brief   : Scans OAM once per line for the next line's sprites and publishes
//           the hits through a double-buffered secondary OAM.
// Revision: 1.0
// ============================================================================
module sprite_line_evaluator #(
    parameter int NUM_ENTRIES = 64,
    parameter int MAX_SPRITES = 8,
    parameter int SPRITE_H    = 16,
    parameter int V_TOTAL     = 525,
    parameter int H_TOTAL     = 800,
    parameter int EVAL_START  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [9:0]                         hcount,
    input  logic [9:0]                         vcount,
    output logic [$clog2(NUM_ENTRIES)-1:0]     oam_addr,
    input  logic [31:0]                        oam_rd_data,
    input  logic [$clog2(MAX_SPRITES)-1:0]     sec_rd_addr,
    output logic [35:0]                        sec_rd_data,
    output logic [$clog2(MAX_SPRITES+1)-1:0]   sec_count,
    output logic                               overflow,
    output logic                               eval_busy
);

    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int SW = $clog2(MAX_SPRITES);
    localparam int CW = $clog2(MAX_SPRITES + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_scan  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    localparam logic [9:0]    c_h_last     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    c_v_last     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    c_eval_start = 10'(EVAL_START);
    localparam logic [9:0]    c_sprite_h   = 10'(SPRITE_H);
    localparam logic [9:0]    c_sprite_hm1 = 10'(SPRITE_H - 1);
    localparam logic [AW-1:0] c_last_addr  = AW'(NUM_ENTRIES - 1);
    localparam logic [CW-1:0] c_max        = CW'(MAX_SPRITES);

    logic [1:0]    r_state;
    logic [9:0]    r_tl;
    logic          r_wbank;
    logic [CW-1:0] r_cnt  [2];
    logic [35:0]   r_bank [2][MAX_SPRITES];

    logic [9:0]    w_tl;
    logic [9:0]    w_y;
    logic [9:0]    w_d;
    logic [3:0]    w_row;
    logic          w_chk;
    logic          w_hit;
    logic          w_swap;
    logic          w_wb_next;
    logic          w_at_start;
    logic [CW-1:0] w_cur_cnt;
    logic          w_store;
    logic          w_drop;

    assign w_tl = (vcount == c_v_last) ? 10'd0 : vcount + 10'd1;

    // Read data lags the address by one cycle, so the first SCAN cycle has
    // nothing to check and DRAIN checks the final entry.
    assign w_chk = ((r_state == c_scan) && (oam_addr != '0)) || (r_state == c_drain);

    assign w_y   = {1'b0, oam_rd_data[18:10]};
    assign w_d   = r_tl - w_y;
    assign w_hit = w_chk && (r_tl >= w_y) && (w_d < c_sprite_h);
    assign w_row = oam_rd_data[30] ? 4'(c_sprite_hm1 - w_d) : w_d[3:0];

    assign w_swap     = (hcount == c_h_last);
    assign w_wb_next  = w_swap ? ~r_wbank : r_wbank;
    assign w_at_start = (hcount == c_eval_start) && ((r_state == c_idle) || w_swap);

    // A swap aborts any scan in flight, so no entry is recorded on that cycle.
    assign w_cur_cnt = r_cnt[r_wbank];
    assign w_store   = w_hit && !w_swap && (w_cur_cnt < c_max);
    assign w_drop    = w_hit && !w_swap && (w_cur_cnt == c_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_tl      <= '0;
            r_wbank   <= 1'b0;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
            oam_addr  <= '0;
            sec_count <= '0;
            overflow  <= 1'b0;
            eval_busy <= 1'b0;
        end else begin
            if (w_swap) begin
                r_wbank   <= ~r_wbank;
                sec_count <= r_cnt[r_wbank];
            end

            if (w_at_start) begin
                r_cnt[w_wb_next] <= '0;
                if (enable) begin
                    r_state   <= c_scan;
                    r_tl      <= w_tl;
                    oam_addr  <= '0;
                    eval_busy <= 1'b1;
                end else begin
                    r_state   <= c_idle;
                    eval_busy <= 1'b0;
                end
            end else if (w_swap) begin
                r_state   <= c_idle;
                oam_addr  <= '0;
                eval_busy <= 1'b0;
            end else begin
                case (r_state)
                    c_scan: begin
                        oam_addr <= oam_addr + AW'(1);
                        if (oam_addr == c_last_addr) begin
                            r_state <= c_drain;
                        end
                    end
                    c_drain: begin
                        r_state   <= c_idle;
                        eval_busy <= 1'b0;
                    end
                    default: r_state <= c_idle;
                endcase
            end

            if (w_store) begin
                r_cnt[r_wbank] <= w_cur_cnt + CW'(1);
            end

            if ((vcount == 10'd0) && (hcount == c_eval_start)) begin
                overflow <= 1'b0;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_store) begin
            r_bank[r_wbank][w_cur_cnt[SW-1:0]] <= {w_row, oam_rd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_rd_data <= '0;
        end else begin
            sec_rd_data <= r_bank[~r_wbank][sec_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_evaluator.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_line_evaluator
// Brief   : Directed, table-driven self-checking bench for the line evaluator.
// Revision: 1.0
// ============================================================================
module tb_sprite_line_evaluator;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [5:0]  oam_addr;
    logic [31:0] oam_rd_data;
    logic [2:0]  sec_rd_addr;
    logic [35:0] sec_rd_data;
    logic [3:0]  sec_count;
    logic        overflow;
    logic        eval_busy;

    logic [31:0] oam [64];

    int checks   = 0;
    int failures = 0;
    logic busy_at64;
    logic busy_at65;

    sprite_line_evaluator dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hcount      (hcount),
        .vcount      (vcount),
        .oam_addr    (oam_addr),
        .oam_rd_data (oam_rd_data),
        .sec_rd_addr (sec_rd_addr),
        .sec_rd_data (sec_rd_data),
        .sec_count   (sec_count),
        .overflow    (overflow),
        .eval_busy   (eval_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous OAM with one cycle of read latency.
    always @(posedge clk) oam_rd_data <= oam[oam_addr];

    typedef struct {
        int v;
        int y;
        int vf;
        int exp_cnt;
        int exp_row;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] mk(input int x, input int y, input int vf);
        logic vbit;
        vbit = (vf != 0);
        return {1'b0, vbit, 1'b0, 4'h3, 6'(x), 9'(y), 10'(x)};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int v);
        for (int h = 0; h < 800; h++) begin
            step(h, v);
            if (h == 64) busy_at64 = eval_busy;
            if (h == 65) busy_at65 = eval_busy;
        end
    endtask

    task automatic read_slot(input int i, output logic [35:0] d);
        sec_rd_addr = 3'(i);
        step(100, int'(vcount));
        d = sec_rd_data;
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) oam[i] = mk(i, 300, 0);
    endtask

    task automatic load_basic();
        clear_oam();
        oam[5]  = mk(5, 100, 0);
        oam[60] = mk(60, 91, 0);
    endtask

    initial begin
        logic [35:0] d;

        // tl = v+1 (or 0 after the last line); entry placed at OAM[17]
        vecs[0] = '{52,  50, 1, 1, 12};
        vecs[1] = '{52,  37, 0, 0, 0};
        vecs[2] = '{52,  38, 0, 1, 15};
        vecs[3] = '{52,  40, 0, 1, 13};
        vecs[4] = '{52,  54, 0, 0, 0};
        vecs[5] = '{52,  53, 1, 1, 15};
        vecs[6] = '{524,  0, 0, 1, 0};
        vecs[7] = '{523,  0, 0, 0, 0};
        vecs[8] = '{52,  38, 1, 1, 0};

        clear_oam();
        reset       = 1'b1;
        enable      = 1'b1;
        hcount      = 10'd100;
        vcount      = 10'd0;
        sec_rd_addr = 3'd0;
        busy_at64   = 1'b0;
        busy_at65   = 1'b1;
        for (int i = 0; i < 3; i++) step(100, 0);

        chk("reset_oam_addr",  36'(oam_addr),  36'd0);
        chk("reset_rd_data",   sec_rd_data,    36'd0);
        chk("reset_sec_count", 36'(sec_count), 36'd0);
        chk("reset_overflow",  36'(overflow),  36'd0);
        chk("reset_busy",      36'(eval_busy), 36'd0);
        reset = 1'b0;
        step(100, 0);

        // Two hits in OAM order, second one at row 9.
        load_basic();
        run_line(99);
        chk("busy_at_h64", 36'(busy_at64), 36'd1);
        chk("busy_at_h65", 36'(busy_at65), 36'd0);
        chk("basic_count", 36'(sec_count), 36'd2);
        read_slot(0, d);
        chk("basic_slot0", d, {4'd0, mk(5, 100, 0)});
        read_slot(1, d);
        chk("basic_slot1", d, {4'd9, mk(60, 91, 0)});
        chk("basic_overflow", 36'(overflow), 36'd0);

        // Single-entry hit-test table.
        for (int k = 0; k < 9; k++) begin
            clear_oam();
            oam[17] = mk(17, vecs[k].y, vecs[k].vf);
            run_line(vecs[k].v);
            chk($sformatf("vec%0d_count", k), 36'(sec_count), 36'(vecs[k].exp_cnt));
            if (vecs[k].exp_cnt != 0) begin
                read_slot(0, d);
                chk($sformatf("vec%0d_slot", k), d,
                    {4'(vecs[k].exp_row), mk(17, vecs[k].y, vecs[k].vf)});
            end
        end

        // Ten hits on one line: eight kept, overflow latched until next frame.
        clear_oam();
        for (int i = 0; i < 10; i++) oam[i] = mk(i, 200, 0);
        run_line(200);
        chk("ovf_count", 36'(sec_count), 36'd8);
        chk("ovf_flag",  36'(overflow),  36'd1);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, d);
            chk($sformatf("ovf_slot%0d", i), d, {4'd1, mk(i, 200, 0)});
        end
        clear_oam();
        run_line(400);
        chk("ovf_sticky_count", 36'(sec_count), 36'd0);
        chk("ovf_sticky", 36'(overflow), 36'd1);
        run_line(524);
        chk("ovf_sticky_last", 36'(overflow), 36'd1);
        step(0, 0);
        chk("ovf_cleared", 36'(overflow), 36'd0);
        for (int h = 1; h < 800; h++) step(h, 0);

        // Enable low suppresses one line, then hits return.
        load_basic();
        enable = 1'b0;
        run_line(99);
        chk("disabled_count", 36'(sec_count), 36'd0);
        enable = 1'b1;
        run_line(99);
        chk("reenabled_count", 36'(sec_count), 36'd2);

        // Reset in the middle of a scan.
        run_line(99);
        chk("pre_reset_count", 36'(sec_count), 36'd2);
        for (int h = 0; h <= 30; h++) step(h, 99);
        chk("midscan_busy", 36'(eval_busy), 36'd1);
        chk("midscan_addr", 36'(oam_addr),  36'd30);
        reset = 1'b1;
        step(31, 99);
        reset = 1'b0;
        chk("rst_busy",  36'(eval_busy), 36'd0);
        chk("rst_count", 36'(sec_count), 36'd0);
        chk("rst_addr",  36'(oam_addr),  36'd0);
        for (int h = 32; h < 800; h++) step(h, 99);
        chk("rst_no_partial", 36'(sec_count), 36'd0);
        run_line(99);
        chk("rst_fresh_count", 36'(sec_count), 36'd2);
        read_slot(1, d);
        chk("rst_fresh_slot1", d, {4'd9, mk(60, 91, 0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
